// File: rtl/xbar_nxn.sv
// xbar_nxn: NCH x NCH valid/ready crossbar with per-output round-robin
// arbitration, one registered slot per output, conflict counter, sticky error.
// Ports: clk, rst_n (async, active-low);
//  input side  i_data, i_valid, i_dest, o_in_ready;
//  output side o_data, o_valid, o_src, i_out_ready;
//  status      o_conflict_cnt (saturating), o_err (bad destination seen).
module xbar_nxn #(
  parameter int DW  = 35,
  parameter int NCH = 4,
  parameter int CW  = 16,
  localparam int SW = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*DW-1:0] i_data,
  input  logic [NCH-1:0]    i_valid,
  input  logic [NCH*SW-1:0] i_dest,
  output logic [NCH-1:0]    o_in_ready,
  output logic [NCH*DW-1:0] o_data,
  output logic [NCH-1:0]    o_valid,
  output logic [NCH*SW-1:0] o_src,
  input  logic [NCH-1:0]    i_out_ready,
  output logic [CW-1:0]     o_conflict_cnt,
  output logic              o_err
);

  function automatic logic [SW-1:0] f_wrap(input int a, input int b);
    return SW'((a + b) % NCH);
  endfunction

  logic [DW-1:0]  w_din     [NCH];
  logic [SW-1:0]  w_dest    [NCH];
  logic [NCH-1:0] w_req     [NCH];
  logic [SW-1:0]  w_gnt_idx [NCH];
  logic [NCH-1:0] w_inr;
  logic [NCH-1:0] w_cap;
  logic [NCH-1:0] w_gnt_any;
  logic [NCH-1:0] w_rdy;
  logic           w_lose;
  logic           w_bad;

  logic [DW-1:0]  r_data [NCH];
  logic [SW-1:0]  r_src  [NCH];
  logic [SW-1:0]  r_ptr  [NCH];
  logic [NCH-1:0] r_valid;
  logic [CW-1:0]  r_cnt;
  logic           r_err;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    assign w_din[g]  = i_data[g*DW +: DW];
    assign w_dest[g] = i_dest[g*SW +: SW];
    assign w_inr[g]  = int'(w_dest[g]) < NCH;
    assign w_cap[g]  = !r_valid[g] || i_out_ready[g];
    assign o_data[g*DW +: DW] = r_data[g];
    assign o_src[g*SW +: SW]  = r_src[g];
  end

  // w_req[j][i]: input i wants output j this cycle
  always_comb begin
    w_gnt_any = '0;
    w_rdy     = '0;
    w_lose    = 1'b0;
    w_bad     = 1'b0;
    for (int j = 0; j < NCH; j++) begin
      w_req[j]     = '0;
      w_gnt_idx[j] = '0;
      for (int i = 0; i < NCH; i++) begin
        w_req[j][i] = i_valid[i] && w_inr[i] &&
                      (w_dest[i] == SW'(j));
      end
    end
    // first requester at or after ptr wins, only if slot can load
    for (int j = 0; j < NCH; j++) begin
      for (int k = 0; k < NCH; k++) begin
        if (w_cap[j] && !w_gnt_any[j] &&
            w_req[j][f_wrap(int'(r_ptr[j]), k)]) begin
          w_gnt_any[j] = 1'b1;
          w_gnt_idx[j] = f_wrap(int'(r_ptr[j]), k);
        end
      end
      if (w_gnt_any[j]) w_rdy[w_gnt_idx[j]] = 1'b1;
    end
    // bad destinations are swallowed; losers only count
    // when their output could actually have loaded
    for (int i = 0; i < NCH; i++) begin
      if (!w_inr[i]) w_rdy[i] = 1'b1;
      if (i_valid[i] && !w_inr[i]) w_bad = 1'b1;
      if (i_valid[i] && w_inr[i] && !w_rdy[i] &&
          w_cap[w_dest[i]]) w_lose = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      for (int j = 0; j < NCH; j++) begin
        r_data[j] <= '0;
        r_src[j]  <= '0;
        r_ptr[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < NCH; j++) begin
        if (w_cap[j]) begin
          if (w_gnt_any[j]) begin
            r_valid[j] <= 1'b1;
            r_data[j]  <= w_din[w_gnt_idx[j]];
            r_src[j]   <= w_gnt_idx[j];
            r_ptr[j]   <= f_wrap(int'(w_gnt_idx[j]), 1);
          end else begin
            r_valid[j] <= 1'b0;
          end
        end
      end
      if (w_lose && r_cnt != {CW{1'b1}})
        r_cnt <= r_cnt + CW'(1);
      if (w_bad) r_err <= 1'b1;
    end
  end

  assign o_in_ready     = w_rdy;
  assign o_valid        = r_valid;
  assign o_conflict_cnt = r_cnt;
  assign o_err          = r_err;

endmodule

// File: tb/tb_xbar_nxn.sv
// tb_xbar_nxn: random and directed checks of xbar_nxn against a
// cycle-level behavioural model (NCH=4) plus an NCH=3, CW=4 instance.
module tb_xbar_nxn;
  localparam int DW  = 35;
  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int CW  = 16;
  localparam int DW3 = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic rst3_n;
  always #5 clk = ~clk;

  logic [N*DW-1:0] i_data;
  logic [N-1:0]    i_valid;
  logic [N*SW-1:0] i_dest;
  logic [N-1:0]    o_in_ready;
  logic [N*DW-1:0] o_data;
  logic [N-1:0]    o_valid;
  logic [N*SW-1:0] o_src;
  logic [N-1:0]    i_out_ready;
  logic [CW-1:0]   o_conflict_cnt;
  logic            o_err;

  logic [3*DW3-1:0] b_data;
  logic [2:0]       b_valid;
  logic [5:0]       b_dest;
  logic [2:0]       b_in_ready;
  logic [3*DW3-1:0] b_o_data;
  logic [2:0]       b_o_valid;
  logic [5:0]       b_o_src;
  logic [2:0]       b_out_ready;
  logic [3:0]       b_cnt;
  logic             b_err;

  xbar_nxn #(.DW(DW), .NCH(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_data(i_data), .i_valid(i_valid), .i_dest(i_dest),
    .o_in_ready(o_in_ready), .o_data(o_data), .o_valid(o_valid),
    .o_src(o_src), .i_out_ready(i_out_ready),
    .o_conflict_cnt(o_conflict_cnt), .o_err(o_err)
  );

  xbar_nxn #(.DW(DW3), .NCH(3), .CW(4)) dut3 (
    .clk(clk), .rst_n(rst3_n),
    .i_data(b_data), .i_valid(b_valid), .i_dest(b_dest),
    .o_in_ready(b_in_ready), .o_data(b_o_data), .o_valid(b_o_valid),
    .o_src(b_o_src), .i_out_ready(b_out_ready),
    .o_conflict_cnt(b_cnt), .o_err(b_err)
  );

  int pass_cnt = 0;
  int total = 0;

  logic [DW-1:0] s_data [N];
  int            s_dest [N];
  logic [N-1:0]  s_valid;

  logic [DW-1:0] m_data [N];
  int            m_src  [N];
  int            m_ptr  [N];
  logic [N-1:0]  m_valid;
  int            m_cnt;

  logic [N-1:0]  e_rdy;
  logic [N-1:0]  e_cap;
  int            e_gnt [N];
  bit            e_lose;

  function automatic logic [DW-1:0] odat(int j);
    return o_data[j*DW +: DW];
  endfunction

  function automatic int osrc(int j);
    return int'(o_src[j*SW +: SW]);
  endfunction

  task automatic model_reset();
    m_valid = '0;
    m_cnt = 0;
    for (int j = 0; j < N; j++) begin
      m_data[j] = '0;
      m_src[j] = 0;
      m_ptr[j] = 0;
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      i_data[i*DW +: DW] = s_data[i];
      i_dest[i*SW +: SW] = 2'(s_dest[i]);
    end
    i_valid = s_valid;
  endtask

  // what the crossbar should accept this cycle
  task automatic model_comb();
    e_rdy = '0;
    e_lose = 0;
    for (int j = 0; j < N; j++) begin
      e_gnt[j] = -1;
      e_cap[j] = !m_valid[j] || i_out_ready[j];
      if (e_cap[j]) begin
        for (int k = 0; k < N; k++) begin
          int src;
          src = (m_ptr[j] + k) % N;
          if (e_gnt[j] < 0 && s_valid[src] && s_dest[src] == j) begin
            e_gnt[j] = src;
            e_rdy[src] = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (s_valid[i] && !e_rdy[i] && e_cap[s_dest[i]]) e_lose = 1;
  endtask

  task automatic model_seq();
    for (int j = 0; j < N; j++) begin
      if (e_gnt[j] >= 0) begin
        m_valid[j] = 1'b1;
        m_data[j] = s_data[e_gnt[j]];
        m_src[j] = e_gnt[j];
        m_ptr[j] = (e_gnt[j] + 1) % N;
      end else if (e_cap[j]) begin
        m_valid[j] = 1'b0;
      end
    end
    if (e_lose && m_cnt < (1 << CW) - 1) m_cnt++;
  endtask

  task automatic settle();
    apply();
    #1;
    model_comb();
  endtask

  task automatic cycle();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic do_reset();
    s_valid = '0;
    apply();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    i_out_ready = '0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < N; i++) begin
        if (c == 0 || e_rdy[i]) s_data[i] = {3'($urandom_range(7)), $urandom};
        s_dest[i] = (i + 1) % N;
      end
      s_valid = '1;
      settle();
      if (c == 1) begin
        total++;
        if (o_in_ready !== 4'h0)
          $display("FAIL full_no_ready: got %b want 0000", o_in_ready);
        else pass_cnt++;
      end
      cycle();
    end
    total++;
    if (o_valid !== 4'hF)
      $display("FAIL preload_valid: got %b want 1111", o_valid);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (o_valid !== '0 || o_data !== '0 || o_src !== '0 ||
        o_conflict_cnt !== '0 || o_err !== 1'b0)
      $display("FAIL async_reset: got v=%b d=%h s=%h c=%0d e=%b want all 0",
               o_valid, o_data, o_src, o_conflict_cnt, o_err);
    else pass_cnt++;
    model_reset();
    s_valid = '0;
    apply();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_out_ready = '1;
    settle();
    cycle();
    total++;
    if (o_valid !== 4'h0)
      $display("FAIL idle_after_reset: got %b want 0000", o_valid);
    else pass_cnt++;
  endtask

  task automatic test_permutation();
    i_out_ready = '1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin
        s_data[i] = DW'(32'h100 + i);
        s_dest[i] = (i + 1) % N;
      end
      s_valid = '1;
      settle();
      total++;
      if (o_in_ready !== 4'hF)
        $display("FAIL perm_ready c%0d: got %b want 1111", c, o_in_ready);
      else pass_cnt++;
      cycle();
      for (int j = 0; j < N; j++) begin
        total++;
        if (o_valid[j] !== 1'b1 || odat(j) !== DW'(32'h100 + (j + 3) % 4) ||
            osrc(j) != (j + 3) % 4)
          $display("FAIL perm_out%0d c%0d: got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                   j, c, o_valid[j], odat(j), osrc(j),
                   32'h100 + (j + 3) % 4, (j + 3) % 4);
        else pass_cnt++;
      end
    end
    total++;
    if (o_conflict_cnt !== '0)
      $display("FAIL perm_cnt: got %0d want 0", o_conflict_cnt);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    do_reset();
    i_out_ready = '1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin
        s_data[i] = DW'(32'h200 + i);
        s_dest[i] = 2;
      end
      s_valid = '1;
      settle();
      total++;
      if (o_in_ready !== 4'(1 << (c % 4)))
        $display("FAIL rr_ready c%0d: got %b want %b", c, o_in_ready,
                 4'(1 << (c % 4)));
      else pass_cnt++;
      cycle();
      total++;
      if (o_valid !== 4'b0100 || osrc(2) != c % 4 ||
          odat(2) !== DW'(32'h200 + c % 4) || o_conflict_cnt !== CW'(c + 1))
        $display("FAIL rr_out c%0d: got v=%b s=%0d d=%h cnt=%0d want v=0100 s=%0d d=%h cnt=%0d",
                 c, o_valid, osrc(2), odat(2), o_conflict_cnt,
                 c % 4, 32'h200 + c % 4, c + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    i_out_ready = 4'b1101;
    s_valid = 4'b1000;
    s_dest[3] = 1;
    s_data[3] = DW'(32'h3A);
    settle();
    cycle();
    s_data[3] = DW'(32'h3B);
    for (int c = 0; c < 5; c++) begin
      settle();
      total++;
      if (o_in_ready[3] !== 1'b0)
        $display("FAIL bp_stall_ready c%0d: got %b want 0", c, o_in_ready[3]);
      else pass_cnt++;
      cycle();
      total++;
      if (o_valid[1] !== 1'b1 || odat(1) !== DW'(32'h3A) || o_conflict_cnt !== '0)
        $display("FAIL bp_hold c%0d: got v=%b d=%h cnt=%0d want v=1 d=3a cnt=0",
                 c, o_valid[1], odat(1), o_conflict_cnt);
      else pass_cnt++;
    end
    i_out_ready = '1;
    settle();
    total++;
    if (o_in_ready[3] !== 1'b1)
      $display("FAIL bp_release_ready: got %b want 1", o_in_ready[3]);
    else pass_cnt++;
    cycle();
    total++;
    if (o_valid[1] !== 1'b1 || odat(1) !== DW'(32'h3B) || osrc(1) != 3)
      $display("FAIL bp_no_bubble: got v=%b d=%h s=%0d want v=1 d=3b s=3",
               o_valid[1], odat(1), osrc(1));
    else pass_cnt++;
    s_valid = '0;
    settle();
    cycle();
    total++;
    if (o_valid !== 4'h0)
      $display("FAIL bp_drain: got %b want 0000", o_valid);
    else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    s_valid = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!s_valid[i] || e_rdy[i]) begin
          s_valid[i] = ($urandom_range(9) < 7);
          s_dest[i] = int'($urandom_range(3));
          s_data[i] = {3'($urandom_range(7)), $urandom};
        end
      end
      i_out_ready = 4'($urandom);
      settle();
      total++;
      if (o_in_ready !== e_rdy)
        $display("FAIL rand_ready c%0d: got %b want %b", c, o_in_ready, e_rdy);
      else pass_cnt++;
      cycle();
      for (int j = 0; j < N; j++) begin
        total++;
        if (o_valid[j] !== m_valid[j] ||
            (m_valid[j] && (odat(j) !== m_data[j] || osrc(j) != m_src[j])))
          $display("FAIL rand_out%0d c%0d: got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                   j, c, o_valid[j], odat(j), osrc(j),
                   m_valid[j], m_data[j], m_src[j]);
        else pass_cnt++;
      end
      total++;
      if (o_conflict_cnt !== CW'(m_cnt) || o_err !== 1'b0)
        $display("FAIL rand_status c%0d: got cnt=%0d err=%b want cnt=%0d err=0",
                 c, o_conflict_cnt, o_err, m_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_sat_err();
    int exp;
    rst3_n = 1'b0;
    b_valid = '0;
    b_out_ready = '1;
    @(posedge clk);
    #1;
    rst3_n = 1'b1;
    b_data = {8'h33, 8'h22, 8'h11};
    b_dest = '0;
    b_valid = 3'b111;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      exp = (c + 1 > 15) ? 15 : c + 1;
      total++;
      if (b_cnt !== 4'(exp))
        $display("FAIL sat_cnt c%0d: got %0d want %0d", c, b_cnt, exp);
      else pass_cnt++;
    end
    b_valid = 3'b001;
    b_dest = 6'b000011;
    #1;
    total++;
    if (b_in_ready[0] !== 1'b1)
      $display("FAIL bad_dest_ready: got %b want 1", b_in_ready[0]);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total++;
    if (b_o_valid !== 3'b000 || b_err !== 1'b1 || b_cnt !== 4'd15)
      $display("FAIL bad_dest_drop: got v=%b err=%b cnt=%0d want v=000 err=1 cnt=15",
               b_o_valid, b_err, b_cnt);
    else pass_cnt++;
    b_valid = '0;
    @(posedge clk);
    #1;
    total++;
    if (b_err !== 1'b1)
      $display("FAIL err_sticky: got %b want 1", b_err);
    else pass_cnt++;
    rst3_n = 1'b0;
    #1;
    total++;
    if (b_err !== 1'b0 || b_cnt !== 4'd0)
      $display("FAIL err_reset: got err=%b cnt=%0d want 0 0", b_err, b_cnt);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    rst3_n = 1'b0;
    i_data = '0;
    i_valid = '0;
    i_dest = '0;
    i_out_ready = '0;
    b_data = '0;
    b_valid = '0;
    b_dest = '0;
    b_out_ready = '0;
    s_valid = '0;
    for (int i = 0; i < N; i++) begin
      s_data[i] = '0;
      s_dest[i] = 0;
      e_gnt[i] = -1;
    end
    e_rdy = '0;
    e_cap = '0;
    e_lose = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_permutation();
    test_round_robin();
    test_backpressure();
    test_random();
    test_sat_err();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/xbar_nxn.md
# xbar_nxn

Parametrised NCH×NCH crossbar for the compression datapath: routes DW-bit words (default 32 data bits plus 3 control bits) from any input lane to any output lane chosen per word by a destination index. It adds valid/ready backpressure, per-output round-robin arbitration, registered outputs and conflict/error reporting. It sits between the lane-packing stages wherever two or more lanes must be steered or swapped.

## Interface
- DW, 35, word width per lane
- NCH, 4, lane count, ≥2; SW = max(1, $clog2(NCH)) is derived, not a parameter
- CW, 16, conflict counter width
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- i_data  in  NCH*DW  input words; lane i at [i*DW +: DW]
- i_valid  in  NCH  input valid per lane
- i_dest  in  NCH*SW  destination output index per lane; lane i at [i*SW +: SW]
- o_in_ready  out  NCH  input-side ready per lane
- o_data  out  NCH*DW  output words; lane j at [j*DW +: DW]
- o_valid  out  NCH  output valid per lane
- o_src  out  NCH*SW  source input index of the word held on output j
- i_out_ready  in  NCH  downstream ready per output lane
- o_conflict_cnt  out  CW  saturating count of arbitration-loss cycles
- o_err  out  1  sticky flag: out-of-range destination seen

## Operation
- Input transfer on lane i: i_valid[i] && o_in_ready[i]. Output transfer on lane j: o_valid[j] && i_out_ready[j].
- Output j has one register slot holding o_data, o_src and o_valid. It can load (cap[j]) when !o_valid[j] || i_out_ready[j].
- Arbitration per output j:
  - Requesters are the inputs i with i_valid[i] && i_dest[i]==j.
  - Priority is round-robin, starting at pointer ptr[j] and increasing with wrap.
  - The grant is issued only when cap[j].
  - o_in_ready[i] = 1 only for the granted input, plus the invalid-dest case below.
- On a grant from input g to output j:
  - o_data[j] ← i_data[g], o_src[j] ← g, o_valid[j] ← 1.
  - ptr[j] ← (g+1) mod NCH.
  - ptr[j] changes only on a grant.
- If cap[j] is true and no input is granted: o_valid[j] ← 0 when i_out_ready[j] is high, otherwise hold.
- Out-of-range destination (i_dest[i] ≥ NCH, possible only when NCH is not a power of 2):
  - The word is accepted (o_in_ready[i]=1) and discarded.
  - o_err ← 1 and stays set until reset.
- Conflict counting:
  - Increment o_conflict_cnt by 1 in any cycle where at least one input with a valid in-range request is not granted while its output has cap=1. Multiple losers in one cycle still add only 1.
  - Backpressure-only stalls (cap=0) do not count.
  - Saturates at 2^CW−1; no wrap.
- The data path does not inspect, modify or reorder word contents. Per-source order to a given output is preserved.

## Timing
- Reset (async assert, sync deassert from the source): o_valid=0, o_data=0, o_src=0, ptr[*]=0, o_conflict_cnt=0, o_err=0.
- Reset asserted mid-transfer drops all held words immediately. No output valid in the cycle after deassert.
- Latency: input accepted at edge N appears on o_valid/o_data after edge N (one cycle).
- Throughput: one word per output per cycle. Distinct destinations proceed fully in parallel.
- o_in_ready is combinational from i_valid, i_dest, i_out_ready and registered state. No path exists from o_in_ready back to any input.
- Upstream holds i_data/i_dest stable while i_valid && !o_in_ready. Downstream holds nothing; o_* are registered.
- Simultaneous drain and load on the same output: both occur and o_valid stays 1 (no bubble).
- With all i_out_ready=0 and every output full: all o_in_ready=0 except inputs with out-of-range destinations.

## Test plan
- Reset and idle. Assert rst_n=0 with traffic in flight -> all outputs 0, counter 0, o_err 0. Release with i_valid=0 -> o_valid stays 0.
- Permutation. NCH=4, all i_out_ready=1, lane i sends 0x100+i to dest (i+1)%4 each cycle for 8 cycles -> every o_in_ready=1; o_data[j]=0x100+(j+3)%4 and o_src[j]=(j+3)%4 one cycle later; o_conflict_cnt stays 0.
- Round-robin contention. Inputs 0–3 all target output 2 continuously with i_out_ready=1 -> grants go 0,1,2,3,0,…; one word per cycle; o_conflict_cnt increments by 1 per cycle.
- Backpressure. Output 1 full and i_out_ready[1]=0 for 5 cycles with input 3 requesting -> o_in_ready[3]=0, o_data[1] held, counter unchanged. Raise i_out_ready[1] -> output 1 drains and loads input 3's word on the same edge with no bubble.
- Saturation and error. CW=4 with 20 conflict cycles -> counter reads 15 and holds. NCH=3 with i_dest=3 on lane 0 -> o_in_ready[0]=1, no output valid, o_err=1 until reset.
